// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: arbitrates stage stall requests,
// redirects the PC on MEM-stage exceptions/ERET, and drains a pending fetch afterwards.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [31:0] ERET_CODE  = 32'h0000000E
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] except_type,
  input  logic [31:0] cp0_epc,
  input  logic        if_busy,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic        new_pc_valid,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]  r_state;
  logic [0:0]  w_next_state;
  logic [31:0] r_stall_cycles;
  logic        w_count;

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    new_pc_valid = 1'b0;
    new_pc       = '0;
    w_next_state = r_state;
    w_count      = 1'b0;

    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
      w_next_state = ST_RUN;
    end else if (r_state == ST_DRAIN) begin
      // The fetch returning from before the redirect is stale: keep discarding it.
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      w_count     = 1'b1;
      if (!if_busy) w_next_state = ST_RUN;
    end else if (except_type != '0) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
      new_pc_valid = 1'b1;
      new_pc       = (except_type == ERET_CODE) ? cp0_epc : EXC_VECTOR;
      w_next_state = if_busy ? ST_DRAIN : ST_RUN;
    end else if (stallreq_mem) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      mem_wb_flush = 1'b1;
      w_count      = 1'b1;
    end else if (stallreq_ex) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      ex_mem_flush = 1'b1;
      w_count      = 1'b1;
    end else if (stallreq_id) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      id_ex_flush = 1'b1;
      w_count     = 1'b1;
    end else if (stallreq_if) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      w_count     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_count && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic,
// all compared against a register-index reference model of the stall/flush rules.
module tb_pipe_ctrl;

  localparam logic [31:0] VEC  = 32'hBFC00380;
  localparam logic [31:0] ERET = 32'h0000000E;

  logic        clk = 1'b0;
  logic        rst, sif, sid, sex, smem, busy;
  logic [31:0] exc, epc;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic        new_pc_valid;
  logic [31:0] new_pc, stall_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic        m_drain;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(.EXC_VECTOR(32'hBFC00380), .ERET_CODE(32'h0000000E)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
    .except_type(exc), .cp0_epc(epc), .if_busy(busy),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .new_pc_valid(new_pc_valid), .new_pc(new_pc), .stall_cycles(stall_cycles)
  );

  // Observation vector: {en[pc..mem_wb] as reg index 4..0, flush[mem_wb..if_id], npv, new_pc, count}
  logic [73:0] obs;
  assign obs = {mem_wb_en, ex_mem_en, id_ex_en, if_id_en, pc_en,
                mem_wb_flush, ex_mem_flush, id_ex_flush, if_id_flush,
                new_pc_valid, new_pc, stall_cycles};

  // Registers indexed 0=pc .. 4=mem_wb; stage s (if=0..mem=3) sits between reg s and reg s+1.
  function automatic void model_expect(output logic [73:0] v, output logic [73:0] m);
    logic [4:0]  en, fl, enm;
    logic        npv;
    logic [31:0] npc;
    int          s;
    en = '1; fl = '0; enm = '1; npv = 1'b0; npc = '0;
    if (rst) begin
      en = '0; fl = '1;
    end else if (m_drain) begin
      en = 5'b11100; fl = 5'b00010; enm[1] = 1'b0;
    end else if (exc != 0) begin
      en = '0; fl = '1; npv = 1'b1;
      npc = (exc == ERET) ? epc : VEC;
    end else begin
      s = smem ? 3 : sex ? 2 : sid ? 1 : sif ? 0 : -1;
      if (s >= 0) begin
        for (int j = 0; j < 5; j++) begin
          en[j] = (j > s + 1);
          fl[j] = (j == s + 1);
        end
        enm[s + 1] = 1'b0;
      end
    end
    v = {en, fl[4:1], npv, npc, m_cnt};
    m = {enm, 4'hF, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFFFFFF) ? c : c + 1;
  endfunction

  // Advance the model across one posedge using the inputs currently applied.
  task automatic cycle_end();
    logic stalled;
    stalled = sif | sid | sex | smem;
    @(posedge clk);
    if (rst) begin
      m_drain = 1'b0; m_cnt = '0;
    end else if (m_drain) begin
      m_cnt = sat_inc(m_cnt);
      if (!busy) m_drain = 1'b0;
    end else if (exc != 0) begin
      m_drain = busy;
    end else if (stalled) begin
      m_cnt = sat_inc(m_cnt);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; sif = 1'b0; sid = 1'b0; sex = 1'b0; smem = 1'b0;
    exc = '0; epc = '0; busy = 1'b0;
  endtask

  task automatic test_reset();
    logic [73:0] ev, em;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); m_drain = 1'b0; m_cnt = '0; @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sex = i[0]; busy = 1'b1;
      #1 model_expect(ev, em); n_checks++;
      if ((obs & em) !== (ev & em))
        $display("FAIL reset_hold[%0d]: got %h required %h", i, obs & em, ev & em);
      else n_pass++;
      cycle_end();
    end
    idle_inputs();
    #1 n_checks++;
    if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
         ex_mem_flush, mem_wb_flush, new_pc_valid, stall_cycles} !== {5'b11111, 4'b0000, 1'b0, 32'd0})
      $display("FAIL reset_release: got en=%b%b%b%b%b fl=%b%b%b%b cnt=%0d required all en, no flush, cnt 0",
               pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, stall_cycles);
    else n_pass++;
    cycle_end();
  endtask

  task automatic test_ex_stall();
    logic [73:0] ev, em;
    logic [31:0] c0;
    for (int rep = 0; rep < 2; rep++) begin
      c0 = m_cnt;
      for (int i = 0; i < 3; i++) begin
        idle_inputs(); sex = 1'b1; sif = (rep == 1);
        #1 model_expect(ev, em); n_checks++;
        if ((obs & em) !== (ev & em))
          $display("FAIL ex_stall[%0d.%0d]: got %h required %h", rep, i, obs & em, ev & em);
        else n_pass++;
        cycle_end();
      end
      idle_inputs();
      #1 n_checks++;
      if (stall_cycles !== c0 + 32'd3)
        $display("FAIL ex_stall_count[%0d]: got %0d required %0d", rep, stall_cycles, c0 + 32'd3);
      else n_pass++;
      cycle_end();
    end
  endtask

  task automatic test_syscall();
    logic [73:0] ev, em;
    idle_inputs(); exc = 32'h8; epc = 32'h12345678;
    #1 model_expect(ev, em); n_checks++;
    if ((obs & em) !== (ev & em) || new_pc !== 32'hBFC00380 || new_pc_valid !== 1'b1)
      $display("FAIL syscall_pulse: got %h required %h", obs & em, ev & em);
    else n_pass++;
    cycle_end();
    idle_inputs();
    #1 model_expect(ev, em); n_checks++;
    if ((obs & em) !== (ev & em))
      $display("FAIL syscall_after: got %h required %h", obs & em, ev & em);
    else n_pass++;
    cycle_end();
  endtask

  task automatic test_eret_drain();
    logic [73:0] ev, em;
    logic [31:0] c0;
    c0 = m_cnt;
    idle_inputs(); exc = ERET; epc = 32'h80001234; busy = 1'b1;
    #1 model_expect(ev, em); n_checks++;
    if ((obs & em) !== (ev & em) || new_pc !== 32'h80001234)
      $display("FAIL eret_pulse: got %h required %h", obs & em, ev & em);
    else n_pass++;
    cycle_end();
    for (int i = 0; i < 4; i++) begin
      // Noise on exception/stall inputs must be ignored while draining
      idle_inputs(); busy = (i < 3); exc = 32'h4; smem = 1'b1;
      #1 model_expect(ev, em); n_checks++;
      if ((obs & em) !== (ev & em) || pc_en !== 1'b0 || if_id_flush !== 1'b1)
        $display("FAIL eret_drain[%0d]: got %h required %h", i, obs & em, ev & em);
      else n_pass++;
      cycle_end();
    end
    idle_inputs();
    #1 model_expect(ev, em); n_checks++;
    if ((obs & em) !== (ev & em) || stall_cycles !== c0 + 32'd4)
      $display("FAIL eret_resume: got %h required %h", obs & em, ev & em);
    else n_pass++;
    cycle_end();
  endtask

  task automatic test_exc_while_stalled();
    logic [73:0] ev, em;
    logic [31:0] c0;
    c0 = m_cnt;
    idle_inputs(); smem = 1'b1; sex = 1'b1; exc = 32'h4;
    #1 model_expect(ev, em); n_checks++;
    if ((obs & em) !== (ev & em) || mem_wb_flush !== 1'b1)
      $display("FAIL exc_stall_pulse: got %h required %h", obs & em, ev & em);
    else n_pass++;
    cycle_end();
    idle_inputs();
    #1 n_checks++;
    if (stall_cycles !== c0)
      $display("FAIL exc_stall_count: got %0d required %0d", stall_cycles, c0);
    else n_pass++;
    cycle_end();
  endtask

  task automatic test_saturate_and_reset_drain();
    logic [73:0] ev, em;
    idle_inputs();
    force dut.r_stall_cycles = 32'hFFFFFFFD;
    #1 release dut.r_stall_cycles;
    m_cnt = 32'hFFFFFFFD;
    for (int i = 0; i < 5; i++) begin
      idle_inputs(); sid = 1'b1;
      #1 model_expect(ev, em); n_checks++;
      if ((obs & em) !== (ev & em))
        $display("FAIL saturate[%0d]: got %h required %h", i, obs & em, ev & em);
      else n_pass++;
      cycle_end();
    end
    idle_inputs();
    #1 n_checks++;
    if (stall_cycles !== 32'hFFFFFFFF)
      $display("FAIL saturate_final: got %h required ffffffff", stall_cycles);
    else n_pass++;
    exc = 32'h8; busy = 1'b1; cycle_end();
    idle_inputs(); busy = 1'b1; cycle_end();
    rst = 1'b1; cycle_end();
    idle_inputs(); busy = 1'b1;
    #1 model_expect(ev, em); n_checks++;
    if ((obs & em) !== (ev & em) || pc_en !== 1'b1 || if_id_flush !== 1'b0)
      $display("FAIL reset_mid_drain: got %h required %h", obs & em, ev & em);
    else n_pass++;
    cycle_end();
  endtask

  task automatic test_random();
    logic [73:0] ev, em;
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(39) == 0);
      sif  = ($urandom_range(3) == 0);
      sid  = ($urandom_range(4) == 0);
      sex  = ($urandom_range(5) == 0);
      smem = ($urandom_range(6) == 0);
      busy = $urandom_range(1) == 1;
      epc  = $urandom;
      case ($urandom_range(9))
        0:       exc = ERET;
        1:       exc = $urandom;
        default: exc = '0;
      endcase
      #1 model_expect(ev, em); n_checks++;
      if ((obs & em) !== (ev & em))
        $display("FAIL random[%0d]: got %h required %h", i, obs & em, ev & em);
      else n_pass++;
      cycle_end();
    end
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_ex_stall();
    test_syscall();
    test_eret_drain();
    test_exc_while_stalled();
    test_saturate_and_reset_drain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the five-stage pipeline.
- Drives the per-stage enable and flush pair of every pipeline register: pc, if_id, id_ex, ex_mem, mem_wb. Each register gives flush priority over en.
- Arbitrates stall requests from the IF, ID, EX and MEM stages, and redirects the PC on exceptions and ERET raised in MEM.
- After a redirect, drains any outstanding instruction-fetch bus transaction before the pipeline resumes.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for every non-ERET exception.
- ERET_CODE, 32'h0000000E, except_type value that denotes ERET.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- stallreq_if  in  1  IF stage requests a stall.
- stallreq_id  in  1  ID stage requests a stall.
- stallreq_ex  in  1  EX stage requests a stall (multi-cycle mul/div).
- stallreq_mem  in  1  MEM stage requests a stall (data bus wait).
- except_type  in  32  MEM-stage exception code; nonzero means exception or ERET.
- cp0_epc  in  32  EPC value used as the ERET target.
- if_busy  in  1  an instruction fetch is outstanding on the bus.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register load enables.
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  stage register bubble insert.
- new_pc_valid  out  1  the PC loads new_pc this cycle, regardless of pc_en.
- new_pc  out  32  redirect target.
- stall_cycles  out  32  performance counter.

Behaviour:
- States: RUN, DRAIN. State is registered; the enable, flush and new_pc outputs are combinational from state, rst and the inputs.
- rst=1 (takes effect at the next posedge, overriding everything):
  - state<=RUN; stall_cycles<=0.
  - While rst is high: all en=0, all flush=1, new_pc_valid=0, new_pc=0.
- RUN, except_type!=0 (exception wins over any stall):
  - All four flush outputs=1; all en=0.
  - new_pc_valid=1.
  - new_pc = cp0_epc if except_type==ERET_CODE, else EXC_VECTOR.
  - Next state: DRAIN if if_busy=1, else RUN.
  - Pulse lasts exactly one cycle.
- RUN, no exception, stall arbitration: the highest stalling stage k wins (mem > ex > id > if).
  - Registers at or before stage k: en=0 (hold).
  - Register immediately after stage k: flush=1 (bubble).
  - All later registers: en=1.
  - stallreq_mem: pc, if_id, id_ex, ex_mem held; mem_wb_flush=1.
  - stallreq_ex: pc, if_id, id_ex held; ex_mem_flush=1; mem_wb_en=1.
  - stallreq_id: pc, if_id held; id_ex_flush=1; ex_mem_en=1, mem_wb_en=1.
  - stallreq_if: pc held; if_id_flush=1; all later en=1.
  - No stall: all en=1, all flush=0.
  - new_pc_valid=0 on every RUN cycle without an exception.
- DRAIN:
  - pc_en=0 and if_id_flush=1 (the stale returning fetch is discarded).
  - id_ex, ex_mem, mem_wb: en=1, flush=0 (they carry bubbles only).
  - new_pc_valid=0.
  - except_type and stall requests are ignored.
  - Leaves for RUN on the first cycle with if_busy=0; that cycle is still a DRAIN cycle.
- stall_cycles:
  - +1 on each RUN cycle where any stallreq=1 and except_type==0.
  - +1 on each DRAIN cycle.
  - Saturates at 32'hFFFFFFFF; no wrap.
  - Never counts while rst is high.
- Simultaneous events:
  - Exception plus stall in the same cycle: the exception is handled and the stall cycle is not counted.
  - Reset during DRAIN: returns to RUN; the drain is abandoned.
- All outputs are defined every cycle; there are no latches and no X outputs.

Test Plan:
- Reset: hold rst 2 cycles -> all flush=1, all en=0, new_pc_valid=0, stall_cycles=0. Release -> all en=1, all flush=0.
- EX stall: stallreq_ex=1 for 3 cycles -> pc/if_id/id_ex en=0, ex_mem_flush=1, mem_wb_en=1 each cycle; stall_cycles=3. Repeat with stallreq_if=1 also high -> identical outputs.
- Syscall: except_type=32'h8, if_busy=0 -> one cycle with all flush=1, new_pc_valid=1, new_pc=32'hBFC00380; next cycle RUN with all en=1.
- ERET with drain: except_type=32'hE, cp0_epc=32'h80001234, if_busy=1 for 3 more cycles ->
  - new_pc=32'h80001234 pulse.
  - Then 3 DRAIN cycles plus the exit cycle: pc_en=0, if_id_flush=1.
  - Return to RUN; stall_cycles+=4.
- Exception while stalled: stallreq_mem=1 and except_type=32'h4 in the same cycle -> flush pulse, mem_wb_flush=1, stall_cycles unchanged.
- Saturation and reset mid-DRAIN:
  - Force the counter near 32'hFFFFFFFF, then stall 5 cycles -> stall_cycles stays 32'hFFFFFFFF.
  - Assert rst during DRAIN -> state returns to RUN after release, even with if_busy=1.
